// File: rtl/steer_sched.sv
// Clocked scheduler producing the one-hot four-phase NCL steer token for a 4-way
// dual-rail steer stage: round-robin grant, DATA/NULL handshake, stall watchdog.
module steer_sched #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1023,
   parameter int CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 init_n,
   input  logic [3:0]           dest_req,
   input  logic [3:0]           dest_mask,
   output logic [3:0]           steer,
   input  logic                 steer_comp,
   output logic                 busy,
   output logic [1:0]           last_grant,
   output logic [4*CNT_W-1:0]   tok_cnt,
   output logic                 err,
   input  logic                 err_clr
);

   // state   | meaning
   // --------+---------------------------------------------------------
   // ST_IDLE | steer=0000, waiting for comp_s=0 and an eligible request
   // ST_DATA | steer=onehot(grant), waiting for completion (comp_s=1)
   // ST_NULL | steer=0000, waiting for the stage to return to NULL

   localparam int SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_NULL = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        steer_q, steer_d;
   logic [1:0]        last_q, last_d;
   logic [CNT_W-1:0]  cnt_q [4];
   logic [CNT_W-1:0]  cnt_d [4];
   logic [WD_W-1:0]   wd_q, wd_d;
   logic              err_q, err_d;
   logic [SS-1:0]     sync_q;

   logic              comp_s;
   logic [3:0]        eligible;
   logic              grant_vld;
   logic [1:0]        grant_idx;

   // steer_comp is asynchronous to clk; only the synchronized copy is used.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SS-2:0], steer_comp};
      end
   end

   assign comp_s   = sync_q[SS-1];
   assign eligible = dest_req & ~dest_mask;

   // Round-robin pick: scan from last_grant+1 upward. Iterating the offsets in
   // descending order lets the nearest eligible index overwrite the farther ones.
   always_comb begin
      logic [1:0] idx;
      grant_vld = 1'b0;
      grant_idx = last_q;
      idx       = last_q;
      for (int k = 4; k >= 1; k--) begin
         idx = last_q + 2'(k);
         if (eligible[idx]) begin
            grant_vld = 1'b1;
            grant_idx = idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      steer_d = steer_q;
      last_d  = last_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      unique case (state_q)
         ST_IDLE: begin
            steer_d = 4'b0000;
            if (!comp_s && grant_vld) begin
               state_d          = ST_DATA;
               steer_d          = 4'b0001 << grant_idx;
               last_d           = grant_idx;
               cnt_d[grant_idx] = cnt_q[grant_idx] + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (comp_s) begin
               state_d = ST_NULL;
               steer_d = 4'b0000;
            end
         end
         ST_NULL: begin
            steer_d = 4'b0000;
            if (!comp_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            steer_d = 4'b0000;
         end
      endcase
   end

   // Watchdog only observes the handshake; it never forces the FSM out of a state.
   always_comb begin
      wd_d  = wd_q;
      err_d = err_q;
      if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         wd_d = '0;
      end else if ((TIMEOUT != 0) && (wd_q != WD_MAX)) begin
         wd_d = wd_q + WD_W'(1);
         if (wd_d == WD_MAX) begin
            err_d = 1'b1;
         end
      end
      if (err_clr) begin
         wd_d  = '0;
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q <= ST_IDLE;
         steer_q <= 4'b0000;
         last_q  <= 2'd3;
         wd_q    <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         steer_q <= steer_d;
         last_q  <= last_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      tok_cnt = '0;
      for (int i = 0; i < 4; i++) begin
         tok_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   assign steer      = steer_q;
   assign busy       = (state_q != ST_IDLE);
   assign last_grant = last_q;
   assign err        = err_q;

   // NCL invariant: at most one rail high, and never a DATA-to-DATA transition.
   a_onehot: assert property (@(posedge clk) disable iff (!init_n) $onehot0(steer_q));
   a_no_d2d: assert property (@(posedge clk) disable iff (!init_n)
                              ((steer_q != 4'b0000) && ($past(steer_q) != 4'b0000))
                              |-> (steer_q == $past(steer_q)));

endmodule
